// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared constants and FSM encoding for the readout voter
// Contents: voter_state_t FSM encoding, default NUM_CLASSES/WIDTH_P/WINDOW/MIN_VALUE
package snn_pkg;

   localparam int NUM_CLASSES_D = 10;
   localparam int WIDTH_D       = 8;
   localparam int WINDOW_D      = 16;
   localparam int MIN_VALUE_D   = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DECIDE  = 2'd2,
      ST_REPORT  = 2'd3
   } voter_state_t;

endpackage

// File: rtl/vote_counter.sv
// rtl/vote_counter.sv - saturating per-class vote counter
// Ports: clk_i clock, rst_i sync active-high reset, clr_i sync clear,
//        inc_i increment enable, count_o current count (sticks at all-ones)
module vote_counter #(
   parameter int CW = 5
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] count_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         count_o <= '0;
      end else if (inc_i && (count_o != '1)) begin
         count_o <= count_o + CW'(1);
      end
   end

endmodule

// File: rtl/readout_voter.sv
// rtl/readout_voter.sv - majority voter over a window of argmax readout samples
// Ports: clk_i clock, rst_i sync active-high reset, start_i window start pulse,
//        idx_i/val_i argmax class and value per cycle, busy_o not idle,
//        result_valid_o/result_ready_i result handshake, class_o decided class
//        (all-ones when no votes), votes_o vote count of class_o
module readout_voter
   import snn_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_D,
   parameter int WIDTH_P     = WIDTH_D,
   parameter int WINDOW      = WINDOW_D,
   parameter int MIN_VALUE   = MIN_VALUE_D
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [WIDTH_P-1:0] idx_i,
   input  logic [WIDTH_P-1:0] val_i,
   output logic               busy_o,
   output logic               result_valid_o,
   input  logic               result_ready_i,
   output logic [WIDTH_P-1:0] class_o,
   output logic [WIDTH_P-1:0] votes_o
);

   localparam int CW = $clog2(WINDOW + 1);
   localparam int SW = $clog2(NUM_CLASSES + 1);

   voter_state_t     state_q, state_d;
   logic [7:0]       samp_q;
   logic [SW-1:0]    scan_q;
   logic [SW-1:0]    best_idx_q;
   logic [CW-1:0]    best_cnt_q;
   logic [CW-1:0]    cur_cnt;
   logic [CW-1:0]    cnt [NUM_CLASSES];
   logic [NUM_CLASSES-1:0] inc;
   logic             vote_ok;
   logic             clr;
   logic             collect_done;
   logic             scan_done;

   // Out-of-range indices never match any counter, so they drop out naturally.
   assign vote_ok = (state_q == ST_COLLECT) && (val_i >= WIDTH_P'(MIN_VALUE));
   assign clr     = (state_q == ST_REPORT) && result_ready_i;

   genvar c;
   generate
      for (c = 0; c < NUM_CLASSES; c++) begin : g_cnt
         assign inc[c] = vote_ok && (idx_i == WIDTH_P'(c));
         vote_counter #(.CW(CW)) u_vote_counter (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (clr),
            .inc_i   (inc[c]),
            .count_o (cnt[c])
         );
      end
   endgenerate

   // Scan mux; scan_q == NUM_CLASSES is the finalize step and selects nothing.
   always_comb begin
      cur_cnt = '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         if (scan_q == SW'(i)) cur_cnt = cnt[i];
      end
   end

   assign collect_done = (samp_q == 8'(WINDOW - 1));
   assign scan_done    = (scan_q == SW'(NUM_CLASSES));

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start_i)        state_d = ST_COLLECT;
         ST_COLLECT: if (collect_done)   state_d = ST_DECIDE;
         ST_DECIDE:  if (scan_done)      state_d = ST_REPORT;
         ST_REPORT:  if (result_ready_i) state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   // Outputs come straight from registers: no input-to-output paths.
   assign busy_o         = (state_q != ST_IDLE);
   assign result_valid_o = (state_q == ST_REPORT);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         samp_q     <= '0;
         scan_q     <= '0;
         best_idx_q <= '0;
         best_cnt_q <= '0;
         class_o    <= '0;
         votes_o    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               samp_q <= '0;
            end
            ST_COLLECT: begin
               samp_q <= samp_q + 8'd1;
               if (collect_done) begin
                  scan_q     <= '0;
                  best_idx_q <= '0;
                  best_cnt_q <= '0;
               end
            end
            ST_DECIDE: begin
               if (!scan_done) begin
                  // Strictly greater keeps the earliest (lowest) index on ties.
                  if (cur_cnt > best_cnt_q) begin
                     best_cnt_q <= cur_cnt;
                     best_idx_q <= scan_q;
                  end
                  scan_q <= scan_q + SW'(1);
               end else begin
                  class_o <= (best_cnt_q == '0) ? '1 : WIDTH_P'(best_idx_q);
                  votes_o <= WIDTH_P'(best_cnt_q);
               end
            end
            ST_REPORT: begin
               if (result_ready_i) begin
                  best_idx_q <= '0;
                  best_cnt_q <= '0;
               end
            end
            default: begin
               samp_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_readout_voter.sv
// tb/tb_readout_voter.sv - directed self-checking bench for readout_voter
module tb_readout_voter;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic [7:0] idx_i;
   logic [7:0] val_i;
   logic       busy_o;
   logic       result_valid_o;
   logic       result_ready_i;
   logic [7:0] class_o;
   logic [7:0] votes_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   readout_voter dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .idx_i          (idx_i),
      .val_i          (val_i),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .class_o        (class_o),
      .votes_o        (votes_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_window();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic feed(input int n, input logic [7:0] idx, input logic [7:0] val);
      for (int i = 0; i < n; i++) begin
         idx_i = idx;
         val_i = val;
         tick();
      end
      idx_i = 8'd0;
      val_i = 8'd0;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 60 && !result_valid_o; i++) tick();
      check(tag, {31'd0, result_valid_o}, 32'd1);
   endtask

   task automatic handshake(input string tag);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      check({tag, "_valid"}, {31'd0, result_valid_o}, 32'd0);
      check({tag, "_busy"},  {31'd0, busy_o},         32'd0);
   endtask

   initial begin
      logic seen;
      rst_i = 1'b1; start_i = 1'b0; idx_i = 8'd0; val_i = 8'd0; result_ready_i = 1'b0;
      tick();
      tick();
      check("rst_busy",  {31'd0, busy_o},         32'd0);
      check("rst_valid", {31'd0, result_valid_o}, 32'd0);
      check("rst_class", {24'd0, class_o},        32'd0);
      check("rst_votes", {24'd0, votes_o},        32'd0);
      rst_i = 1'b0;
      tick();

      // idx=3 val=150 x16, exact latency 27 edges after start
      start_window();
      check("t1_busy", {31'd0, busy_o}, 32'd1);
      feed(16, 8'd3, 8'd150);
      for (int i = 0; i < 10; i++) tick();
      check("t1_early_valid", {31'd0, result_valid_o}, 32'd0);
      check("t1_early_class", {24'd0, class_o},        32'd0);
      tick();
      check("t1_valid", {31'd0, result_valid_o}, 32'd1);
      check("t1_class", {24'd0, class_o},        32'd3);
      check("t1_votes", {24'd0, votes_o},        32'd16);
      handshake("t1_hs");
      check("t1_class_held", {24'd0, class_o}, 32'd3);

      // back-to-back: tie 8/8 between class 5 and 2 resolves to 2; hold 5 cycles
      start_window();
      check("t2_b2b_busy", {31'd0, busy_o}, 32'd1);
      feed(8, 8'd5, 8'd75);
      feed(8, 8'd2, 8'd75);
      wait_valid("t2_wait");
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t2_hold_valid", {31'd0, result_valid_o}, 32'd1);
         check("t2_hold_class", {24'd0, class_o},        32'd2);
         check("t2_hold_votes", {24'd0, votes_o},        32'd8);
      end
      handshake("t2_hs");
      tick();
      check("t2_one_hs", {31'd0, result_valid_o}, 32'd0);

      // all val=0 -> no votes
      start_window();
      feed(16, 8'd3, 8'd0);
      wait_valid("t3a_wait");
      check("t3a_class", {24'd0, class_o}, 32'hFF);
      check("t3a_votes", {24'd0, votes_o}, 32'd0);
      handshake("t3a_hs");

      // idx=12 out of range -> no votes
      start_window();
      feed(16, 8'd12, 8'd200);
      wait_valid("t3b_wait");
      check("t3b_class", {24'd0, class_o}, 32'hFF);
      check("t3b_votes", {24'd0, votes_o}, 32'd0);
      handshake("t3b_hs");

      // boundaries: val=MIN_VALUE counts, idx=NUM_CLASSES-1 counts, idx=10 dropped
      start_window();
      feed(6, 8'd9,  8'd1);
      feed(5, 8'd10, 8'd200);
      feed(5, 8'd0,  8'd0);
      wait_valid("t3c_wait");
      check("t3c_class", {24'd0, class_o}, 32'd9);
      check("t3c_votes", {24'd0, votes_o}, 32'd6);
      handshake("t3c_hs");

      // reset on sample 7 of an idx=4 window
      start_window();
      feed(7, 8'd4, 8'd100);
      rst_i = 1'b1;
      idx_i = 8'd4; val_i = 8'd100;
      tick();
      rst_i = 1'b0; idx_i = 8'd0; val_i = 8'd0;
      check("t5_rst_busy",  {31'd0, busy_o},         32'd0);
      check("t5_rst_valid", {31'd0, result_valid_o}, 32'd0);
      check("t5_rst_class", {24'd0, class_o},        32'd0);
      check("t5_rst_votes", {24'd0, votes_o},        32'd0);
      // 5 votes for class 1: any class-4 residue (7) would win
      start_window();
      feed(5, 8'd1, 8'd50);
      feed(11, 8'd1, 8'd0);
      wait_valid("t5a_wait");
      check("t5a_class", {24'd0, class_o}, 32'd1);
      check("t5a_votes", {24'd0, votes_o}, 32'd5);
      handshake("t5a_hs");
      start_window();
      feed(16, 8'd1, 8'd50);
      wait_valid("t5b_wait");
      check("t5b_class", {24'd0, class_o}, 32'd1);
      check("t5b_votes", {24'd0, votes_o}, 32'd16);
      handshake("t5b_hs");

      // start_i held through COLLECT and part of DECIDE is ignored
      start_window();
      start_i = 1'b1;
      feed(16, 8'd7, 8'd9);
      tick();
      tick();
      tick();
      start_i = 1'b0;
      wait_valid("t6_wait");
      check("t6_class", {24'd0, class_o}, 32'd7);
      check("t6_votes", {24'd0, votes_o}, 32'd16);
      handshake("t6_hs");
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         seen = seen | result_valid_o | busy_o;
      end
      check("t6_no_extra", {31'd0, seen}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
